// File: rtl/sort_floats_serial_fsm.sv
// Serial three-float ascending sorter: collect 3 elements, 3 bubble compares on one shared comparator.
// Result valid 4 cycles after the third accept; held indefinitely under out_ready=0, no input accepted until drained.

`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal #(
  parameter int W = `FLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         res,
  output logic         err
);
  localparam int EW = (W == 16) ? 5 : (W == 32) ? 8 : 11;
  localparam int MW = W - 1 - EW;

  logic a_nan, b_nan, both_zero;

  assign a_nan     = (&a[W-2:MW]) && (|a[MW-1:0]);
  assign b_nan     = (&b[W-2:MW]) && (|b[MW-1:0]);
  assign both_zero = ~(|a[W-2:0]) && ~(|b[W-2:0]);

  // Sign-magnitude ordering; -0 and +0 are treated as equal.
  always_comb begin
    err = a_nan || b_nan;
    res = 1'b0;
    if (err)
      res = 1'b0;
    else if (both_zero)
      res = 1'b1;
    else if (a[W-1] != b[W-1])
      res = a[W-1];
    else if (!a[W-1])
      res = (a[W-2:0] <= b[W-2:0]);
    else
      res = (a[W-2:0] >= b[W-2:0]);
  end
endmodule

module sort_floats_serial_fsm (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [`FLEN-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:2][`FLEN-1:0]   out_sorted,
  output logic                    out_err
);
  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    CMP_A   = 3'd1,
    CMP_B   = 3'd2,
    CMP_C   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  state;
  logic [1:0]              cnt;
  logic [0:2][`FLEN-1:0]   elem;
  logic [0:2][`FLEN-1:0]   elem_swp;
  logic                    err_sticky;
  logic [`FLEN-1:0]        op_a, op_b;
  logic                    cmp_res, cmp_err;

  assign in_ready = (state == COLLECT) && rst;

  f_less_or_equal #(.W(`FLEN)) u_cmp (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  // CMP_B works on pair (1,2); every other state presents pair (0,1).
  always_comb begin
    op_a     = (state == CMP_B) ? elem[1] : elem[0];
    op_b     = (state == CMP_B) ? elem[2] : elem[1];
    elem_swp = elem;
    if (!cmp_res && !cmp_err) begin
      if (state == CMP_B) begin
        elem_swp[1] = elem[2];
        elem_swp[2] = elem[1];
      end else begin
        elem_swp[0] = elem[1];
        elem_swp[1] = elem[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= COLLECT;
      cnt        <= 2'd0;
      elem       <= '0;
      err_sticky <= 1'b0;
      out_sorted <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid && in_ready) begin
            case (cnt)
              2'd0:    elem[0] <= in_data;
              2'd1:    elem[1] <= in_data;
              default: elem[2] <= in_data;
            endcase
            if (cnt >= 2'd2) begin
              cnt        <= 2'd0;
              err_sticky <= 1'b0;
              state      <= CMP_A;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        CMP_A: begin
          elem       <= elem_swp;
          err_sticky <= err_sticky | cmp_err;
          state      <= CMP_B;
        end
        CMP_B: begin
          elem       <= elem_swp;
          err_sticky <= err_sticky | cmp_err;
          state      <= CMP_C;
        end
        CMP_C: begin
          elem       <= elem_swp;
          out_sorted <= elem_swp;
          out_err    <= err_sticky | cmp_err;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
          cnt   <= 2'd0;
        end
      endcase
    end
  end
endmodule
